truth_table_sweeper: RTL and testbench

//  Sequential stimulus-and-capture stage wrapped around a 4-input combinational

---
 rtl/truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives {a,b,c,d} through 0..15 and captures y_in.
// Optional golden-table compare when TT_COMPARE_EN is defined.
module truth_table_sweeper #(
  parameter int NUM_IN        = 4,
  parameter int TT_W          = 1 << NUM_IN,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y_in,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] table_out
`ifdef TT_COMPARE_EN
  ,
  input  logic [TT_W-1:0]   expected,
  output logic              match,
  output logic [NUM_IN-1:0] first_err
`endif
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [NUM_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t            state;
  logic [NUM_IN-1:0] idx;
  logic [NUM_IN-1:0] vec;
  logic [7:0]        cnt;

  logic sample;
  logic last;

  assign sample = (state == SWEEP) && (cnt == 8'd0);
  assign last   = sample && (idx == LAST);
  assign {a, b, c, d} = vec;

  // Sweep sequencer: hold each vector SETTLE+1 clocks, capture y_in on the last
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      vec       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          vec  <= '0;
          if (start) begin
            table_out <= '0;
            idx       <= '0;
            vec       <= '0;
            cnt       <= SETTLE;
            busy      <= 1'b1;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          if (cnt == 8'd0) begin
            table_out[idx] <= y_in;
            if (idx == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              vec   <= '0;
            end else begin
              idx <= idx + 1'b1;
              vec <= idx + 1'b1;
              cnt <= SETTLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  logic [TT_W-1:0]   exp_q;
  logic [TT_W-1:0]   final_tt;
  logic [NUM_IN-1:0] err_idx;

  // Completed table including the bit captured this edge; lowest differing bit
  always_comb begin
    final_tt       = table_out;
    final_tt[LAST] = y_in;
    err_idx        = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (final_tt[i] != exp_q[i]) err_idx = NUM_IN'(i);
    end
  end

  // Golden table latched on start; verdict registered alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q     <= '0;
      match     <= 1'b0;
      first_err <= '0;
    end else if (state == IDLE && start) begin
      exp_q     <= expected;
      match     <= 1'b0;
      first_err <= '0;
    end else if (last) begin
      match     <= (final_tt == exp_q);
      first_err <= (final_tt == exp_q) ? '0 : err_idx;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 2 and settle 0)
// driven by behavioural function models, checked against hand tables.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [2];
  logic        y_s     [2];
  logic        a_s     [2];
  logic        b_s     [2];
  logic        c_s     [2];
  logic        d_s     [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [15:0] tt_s    [2];
  logic [3:0]  mode_s  [2];
`ifdef TT_COMPARE_EN
  logic [15:0] exp_s   [2];
  logic        match_s [2];
  logic [3:0]  ferr_s  [2];
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic model(input logic [3:0] m, input logic [3:0] v);
    logic aa, bb, cc, dd;
    {aa, bb, cc, dd} = v;
    case (m)
      4'd0:    return (aa & bb) | (cc & dd);
      4'd1:    return aa ^ bb ^ cc ^ dd;
      4'd2:    return 1'b1;
      4'd3:    return 1'b0;
      4'd4:    return aa;
      4'd5:    return dd;
      4'd6:    return ((aa & bb) | (cc & dd)) ^ (v == 4'd5);
      default: return 1'b0;
    endcase
  endfunction

  assign y_s[0] = model(mode_s[0], {a_s[0], b_s[0], c_s[0], d_s[0]});
  assign y_s[1] = model(mode_s[1], {a_s[1], b_s[1], c_s[1], d_s[1]});

  truth_table_sweeper #(.SETTLE_CYCLES(2)) u0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s[0]),
    .y_in      (y_s[0]),
    .a         (a_s[0]),
    .b         (b_s[0]),
    .c         (c_s[0]),
    .d         (d_s[0]),
    .busy      (busy_s[0]),
    .done      (done_s[0]),
    .table_out (tt_s[0])
`ifdef TT_COMPARE_EN
    ,
    .expected  (exp_s[0]),
    .match     (match_s[0]),
    .first_err (ferr_s[0])
`endif
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0)) u1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s[1]),
    .y_in      (y_s[1]),
    .a         (a_s[1]),
    .b         (b_s[1]),
    .c         (c_s[1]),
    .d         (d_s[1]),
    .busy      (busy_s[1]),
    .done      (done_s[1]),
    .table_out (tt_s[1])
`ifdef TT_COMPARE_EN
    ,
    .expected  (exp_s[1]),
    .match     (match_s[1]),
    .first_err (ferr_s[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] vec_of(input int s);
    return {a_s[s], b_s[s], c_s[s], d_s[s]};
  endfunction

  task automatic chk_idle(input int s, input logic [15:0] tt);
    chk($sformatf("idle_vec%0d", s), 32'(vec_of(s)), 32'd0);
    chk($sformatf("idle_busy%0d", s), 32'(busy_s[s]), 32'd0);
    chk($sformatf("idle_done%0d", s), 32'(done_s[s]), 32'd0);
    chk($sformatf("idle_tt%0d", s), 32'(tt_s[s]), 32'(tt));
  endtask

  task automatic run_sweep(input int s, input logic [3:0] m,
                           input logic [15:0] tt, input int restart_at,
                           input int rst_at);
    int  per;
    int  lat;
    bit  seen;
    per  = (s == 0) ? 3 : 1;
    lat  = 16 * per + 1;
    seen = 1'b0;
    mode_s[s] = m;
    @(negedge clk);
    start_s[s] = 1'b1;
    for (int n = 1; n <= lat + 5; n++) begin
      @(negedge clk);
      start_s[s] = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(s, 16'h0000);
        return;
      end
      if (done_s[s]) begin
        chk("done_cycle", 32'(n), 32'(lat));
        chk("table", 32'(tt_s[s]), 32'(tt));
        chk("done_busy", 32'(busy_s[s]), 32'd0);
        chk("done_vec", 32'(vec_of(s)), 32'd0);
        seen = 1'b1;
        break;
      end
      chk("sweep_vec", 32'(vec_of(s)), 32'((n - 1) / per));
      chk("sweep_busy", 32'(busy_s[s]), 32'd1);
      if (n == restart_at) start_s[s] = 1'b1;
    end
    if (!seen) begin
      chk("timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk_idle(s, tt);
    end
  endtask

  typedef struct {
    int         sel;
    logic [3:0] mode;
    logic [15:0] tt;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{0, 4'd0, 16'hF888};
    vt[1] = '{1, 4'd1, 16'h6996};
    vt[2] = '{0, 4'd2, 16'hFFFF};
    vt[3] = '{1, 4'd3, 16'h0000};
    vt[4] = '{0, 4'd4, 16'hFF00};
    vt[5] = '{1, 4'd5, 16'hAAAA};
    vt[6] = '{0, 4'd1, 16'h6996};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 4'd0;
`ifdef TT_COMPARE_EN
      exp_s[i] = 16'h0000;
`endif
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle(0, 16'h0000);
    chk_idle(1, 16'h0000);
`ifdef TT_COMPARE_EN
    chk("rst_match", 32'(match_s[0]), 32'd0);
    chk("rst_ferr", 32'(ferr_s[0]), 32'd0);
`endif

    for (int i = 0; i < 7; i++) begin
      run_sweep(vt[i].sel, vt[i].mode, vt[i].tt, -1, -1);
    end

    // start at vector 7 ignored: single done at the normal cycle
    run_sweep(0, 4'd0, 16'hF888, 22, -1);
    @(negedge clk);
    chk("no_restart_busy", 32'(busy_s[0]), 32'd0);

    // rst at vector 9 discards the partial table, then a clean sweep
    run_sweep(0, 4'd2, 16'hFFFF, -1, 28);
    run_sweep(0, 4'd2, 16'hFFFF, -1, -1);

    // start coincident with rst: rst wins
    @(negedge clk);
    rst = 1'b1;
    start_s[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_s[0] = 1'b0;
    @(negedge clk);
    chk_idle(0, 16'h0000);

`ifdef TT_COMPARE_EN
    exp_s[0] = 16'hF888;
    run_sweep(0, 4'd6, 16'hF8A8, -1, -1);
    chk("bad_match", 32'(match_s[0]), 32'd0);
    chk("bad_ferr", 32'(ferr_s[0]), 32'd5);
    run_sweep(0, 4'd0, 16'hF888, -1, -1);
    chk("good_match", 32'(match_s[0]), 32'd1);
    chk("good_ferr", 32'(ferr_s[0]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
